aes_cipher_ctrl: RTL
====================

AES_CIPHER_CTRL -- requirements
Module: aes_cipher_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 10: the number of cipher rounds; legal range 1..10, where values below 10 are reduced-round test builds.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; every flop is rising-edge triggered.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: a key/data pair is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a pair this cycle.
REQ-006 SHALL have port in_key, input, 128 bits (t_opaque_AESKey): the cipher key.
REQ-007 SHALL have port in_data, input, 128 bits (t_opaque_AESData): the plaintext.
REQ-008 SHALL have port out_valid, output, 1 bit: a ciphertext is held on out_data.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes the ciphertext.
REQ-010 SHALL have port out_data, output, 128 bits (t_opaque_AESData): the ciphertext.
REQ-011 SHALL have port busy, output, 1 bit: high in states ROUND and DONE.

Function
REQ-012 SHALL implement a state machine with states IDLE, ROUND and DONE, holding registers st (128 bits), rkey (128 bits) and rnd (4 bits).
REQ-013 SHALL drive in_ready = (state == IDLE), combinationally.
REQ-014 SHALL, on a clock edge with in_valid && in_ready, load st = in_data ^ in_key, rkey = in_key and rnd = 1, and enter ROUND.
REQ-015 SHALL, on each clock edge in ROUND, compute nk = key_step(rkey, RCON[rnd-1]).
REQ-016 SHALL, on that same edge, load st = round(st, nk, final = (rnd == ROUNDS)), load rkey = nk, and increment rnd.
REQ-017 SHALL, in ROUND, omit MixColumns only when rnd == ROUNDS, and enter DONE on that edge.
REQ-018 SHALL, in DONE, assert out_valid with out_data = st held stable until out_ready is high.
REQ-019 SHALL, on a clock edge in DONE with out_ready high, return to IDLE.
REQ-020 SHALL meet this latency: out_valid is first high exactly ROUNDS edges after the accepting edge.
REQ-021 SHALL meet this throughput: at best one block per ROUNDS+2 cycles.
REQ-022 SHALL ignore in_valid outside IDLE and SHALL NOT sample in_key or in_data there.
REQ-023 SHALL, under backpressure (out_ready low), hold out_valid, out_data and state indefinitely.
REQ-024 SHALL drive out_data = 0 whenever out_valid is low.
REQ-025 SHALL have rnd never exceed ROUNDS; if rnd is out of range in ROUND, go to IDLE.

Reset
REQ-026 SHALL, while rst is low, asynchronously force state = IDLE, st = 0, rkey = 0, rnd = 0, out_valid = 0, busy = 0 and in_ready = 1.
REQ-027 SHALL, on reset assertion mid-operation, discard the block in flight without producing any output.
REQ-028 SHALL, after reset release, be able to accept on the first clock edge.

Configuration
REQ-029 SHALL, with macro AES_CIPHER_CTRL_ABORT_EN defined, add port abort (input, 1 bit).
REQ-030 SHALL, with that macro defined and abort high on an edge in ROUND or DONE, go to IDLE and clear st, rkey, rnd and out_valid.
REQ-031 SHALL, with that macro defined, ignore abort in IDLE, so an accept in the same cycle proceeds.
REQ-032 SHALL, without that macro, have no abort port and no abort logic.

Structure
REQ-033 SHALL take t_opaque_AESKey, t_opaque_AESData, the RCON table (01,02,04,08,10,20,40,80,1B,36), the SBOX table and the state-encoding typedef from the shared package aes_pkg.
REQ-034 SHALL place the combinational round datapath (SubBytes, ShiftRows, optional MixColumns, AddRoundKey) together with key_step in one sub-module, aes_round_step.
REQ-035 SHALL keep all sequencing in aes_cipher_ctrl.

Verification
REQ-036 SHALL cover FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, 10 cycles after accept.
REQ-037 SHALL cover FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
REQ-038 SHALL cover backpressure and ignored input: out_ready low for 20 cycles and in_valid held high with new data -> out_valid and out_data stable, the second pair accepted only after the DONE->IDLE edge.
REQ-039 SHALL cover back-to-back: 2 pairs with out_ready = 1 -> accepts exactly 12 cycles apart and both results correct.
REQ-040 SHALL cover reset mid-operation: rst low during round 5 -> out_valid = 0, in_ready = 1 immediately; the next block's result is correct.
REQ-041 SHALL cover abort (with AES_CIPHER_CTRL_ABORT_EN): abort in round 3 -> no out_valid and IDLE on the next edge; abort in IDLE with in_valid high -> the block is accepted.

Source files
------------

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions used by the cipher controller and its round
// datapath: opaque key/data types, the controller state encoding, the key
// schedule round constants, the forward S-box and the GF(2^8) xtime helper.
// No ports (package).
// -----------------------------------------------------------------------------
package aes_pkg;

  typedef logic [127:0] t_opaque_AESKey;
  typedef logic [127:0] t_opaque_AESData;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Round constants for key expansion, indexed by round number minus one.
  localparam logic [0:9][7:0] RCON = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // NOTE: SBOX is a constant lookup table, not storage, so it has no reset and
  // synthesises to pure combinational logic.
  localparam logic [0:255][7:0] SBOX = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x (0x02) in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_step.sv
// -----------------------------------------------------------------------------
// aes_round_step
// Purely combinational AES-128 encryption round plus one key-schedule step.
// The next round key is derived first and used as this round's AddRoundKey
// operand, so the controller only has to register both results each edge.
//
// Ports
//   st        in   128  current cipher state (byte 0 in bits 127:120)
//   rkey      in   128  previous round key
//   rcon      in     8  round constant for this key step
//   is_final  in     1  final round: MixColumns is bypassed
//   st_next   out  128  state after SubBytes/ShiftRows/[MixColumns]/AddRoundKey
//   nk        out  128  next round key
// -----------------------------------------------------------------------------
module aes_round_step
  import aes_pkg::*;
(
  input  t_opaque_AESData st,
  input  t_opaque_AESKey  rkey,
  input  logic [7:0]      rcon,
  input  logic            is_final,
  output t_opaque_AESData st_next,
  output t_opaque_AESKey  nk
);

  // Byte view of the state: index i = row + 4*column, byte 0 is the MSB.
  logic [0:15][7:0] in_b;
  logic [0:15][7:0] sb;
  logic [0:15][7:0] sr;
  logic [0:15][7:0] mc;

  assign in_b = st;

  // SubBytes
  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[i] = SBOX[in_b[i]];
  end

  // ShiftRows: row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_shift_col
    for (genvar r = 0; r < 4; r++) begin : g_shift_row
      assign sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
    end
  end

  // MixColumns: each column multiplied by the circulant {02,03,01,01}.
  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*c];
    assign a1 = sr[4*c + 1];
    assign a2 = sr[4*c + 2];
    assign a3 = sr[4*c + 3];
    assign mc[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  // Key step: temp = SubWord(RotWord(w3)) ^ {rcon, 0, 0, 0}, then chain.
  logic [31:0]     w0, w1, w2, w3;
  logic [31:0]     n0, n1, n2, n3;
  logic [0:3][7:0] rot_b;
  logic [0:3][7:0] sub_w;
  logic [31:0]     temp;

  assign {w0, w1, w2, w3} = rkey;
  assign rot_b = {w3[23:0], w3[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_subword
    assign sub_w[j] = SBOX[rot_b[j]];
  end

  assign temp = sub_w ^ {rcon, 24'h000000};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;
  assign nk   = {n0, n1, n2, n3};

  // AddRoundKey with the freshly derived key.
  assign st_next = (is_final ? sr : mc) ^ nk;

endmodule

// File: rtl/aes_cipher_ctrl.sv
// -----------------------------------------------------------------------------
// aes_cipher_ctrl
// Iterative AES-128 encryption engine: one round per clock. A key/data pair is
// accepted in IDLE, ROUNDS round edges later the ciphertext is presented in
// DONE and held until the consumer takes it.
//
// Parameters
//   ROUNDS     number of cipher rounds (1..10; below 10 only for test builds)
//
// Ports
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous reset, active low
//   in_valid   in   1    key/data pair offered
//   in_ready   out  1    pair accepted this cycle (state IDLE)
//   in_key     in   128  cipher key
//   in_data    in   128  plaintext
//   out_valid  out  1    ciphertext held on out_data (state DONE)
//   out_ready  in   1    consumer takes the ciphertext
//   out_data   out  128  ciphertext, zero while out_valid is low
//   abort      in   1    only with AES_CIPHER_CTRL_ABORT_EN: drop the block in
//                        flight (ignored in IDLE)
//   busy       out  1    high in ROUND and DONE
//
// Configuration macro: AES_CIPHER_CTRL_ABORT_EN adds the abort port and logic.
// -----------------------------------------------------------------------------
module aes_cipher_ctrl
  import aes_pkg::*;
#(
  parameter int ROUNDS = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  t_opaque_AESKey  in_key,
  input  t_opaque_AESData in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output t_opaque_AESData out_data,
`ifdef AES_CIPHER_CTRL_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy
);

  localparam logic [3:0] LAST_RND = 4'(ROUNDS);

  state_e          state;
  state_e          state_next;
  t_opaque_AESData st;
  t_opaque_AESKey  rkey;
  logic [3:0]      rnd;

  t_opaque_AESData st_next;
  t_opaque_AESKey  nk;
  logic [3:0]      rcon_idx;
  logic [7:0]      rcon;
  logic            rnd_ok;
  logic            last_rnd;
  logic            kill;

  // A round counter outside 1..ROUNDS can only come from an upset; the
  // sequencer then drops the block instead of indexing past the RCON table.
  assign rnd_ok   = (rnd != 4'd0) && (rnd <= LAST_RND);
  assign last_rnd = (rnd == LAST_RND);
  assign rcon_idx = rnd - 4'd1;
  assign rcon     = rnd_ok ? RCON[rcon_idx] : 8'h00;

`ifdef AES_CIPHER_CTRL_ABORT_EN
  // Abort is only meaningful with a block in flight; in IDLE it is ignored so
  // a same-cycle accept still proceeds.
  assign kill = abort && (state != IDLE);
`else
  assign kill = 1'b0;
`endif

  aes_round_step u_round_step (
    .st       (st),
    .rkey     (rkey),
    .rcon     (rcon),
    .is_final (last_rnd),
    .st_next  (st_next),
    .nk       (nk)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values of its sources, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_next is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (in_valid) state_next = ROUND;
      ROUND: begin
        if (!rnd_ok)       state_next = IDLE;
        else if (last_rnd) state_next = DONE;
      end
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (kill) state_next = IDLE;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == ROUND) || (state == DONE);
    out_data  = out_valid ? st : '0;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= '0;
      rkey <= '0;
      rnd  <= '0;
    end else if (kill) begin
      st   <= '0;
      rkey <= '0;
      rnd  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            st   <= in_data ^ in_key;
            rkey <= in_key;
            rnd  <= 4'd1;
          end
        end
        ROUND: begin
          if (rnd_ok) begin
            st   <= st_next;
            rkey <= nk;
            // Hold on the final round so rnd never exceeds ROUNDS.
            if (!last_rnd) rnd <= rnd + 4'd1;
          end else begin
            rnd <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
